// File: rtl/pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_chain
//  Purpose  : Elastic pipeline register chain. DEPTH stages of WIDTH-bit
//             payload, each with its own valid bit. Provides valid/ready
//             handshakes at both ends, bubble collapsing, a global stall,
//             a synchronous flush and a registered occupancy count.
//  Ports    : Clk        - rising-edge clock
//             Reset      - asynchronous, active-low reset
//             stall      - freeze all stages, mask both handshakes
//             flush      - clear all valid bits at the next edge
//             in_valid   - upstream beat present
//             in_data    - upstream payload
//             in_ready   - chain accepts a beat this cycle
//             out_valid  - beat present at the chain output
//             out_data   - payload of the last stage (always driven)
//             out_ready  - downstream accepts this cycle
//             count      - number of valid stages
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_chain #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter bit CLEAR_DATA = 1'b0
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int C_CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [C_CW-1:0]  r_count;

    logic [DEPTH-1:0] w_rdy;
    logic [DEPTH-1:0] w_src_v;
    logic [WIDTH-1:0] w_src_d [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [C_CW-1:0]  w_count_nxt;

    // Ready ripples from the output back to the input. An empty stage is
    // always ready, which is what lets upstream beats slide into bubbles
    // even while the downstream consumer is not accepting.
    always_comb begin
        logic l_rdy;
        l_rdy = out_ready;
        w_rdy = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            l_rdy    = !r_v[i] || l_rdy;
            w_rdy[i] = l_rdy;
        end
    end

    // Each stage loads from its upstream neighbour; stage 0 loads from the port.
    always_comb begin
        w_src_v[0] = in_valid;
        w_src_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_src_v[i] = r_v[i-1];
            w_src_d[i] = r_d[i-1];
        end
    end

    assign in_ready   = w_rdy[0] && !stall && !flush && Reset;
    assign out_valid  = r_v[DEPTH-1] && !stall && !flush;
    assign out_data   = r_d[DEPTH-1];
    assign count      = r_count;

    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = out_valid && out_ready;
    assign w_count_nxt = r_count + C_CW'(w_in_xfer) - C_CW'(w_out_xfer);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            // Flush has priority over stall.
            r_v     <= '0;
            r_count <= '0;
            if (CLEAR_DATA) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_d[i] <= '0;
                end
            end
        end else if (!stall) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_rdy[i]) begin
                    r_v[i] <= w_src_v[i];
                    // Payload only moves with a valid beat so that an empty
                    // stage keeps its last contents.
                    if (w_src_v[i]) begin
                        r_d[i] <= w_src_d[i];
                    end
                end
            end
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_chain
//  Purpose  : Self-checking bench for pipe_stage_chain (WIDTH=8, DEPTH=3).
//             A second instance with CLEAR_DATA=1 shares the stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_chain;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       stall, flush, in_valid, out_ready;
    logic [7:0] in_data;
    logic       in_ready, out_valid, in_ready_c, out_valid_c;
    logic [7:0] out_data, out_data_c;
    logic [1:0] count, count_c;

    int errs   = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    pipe_stage_chain #(.WIDTH(8), .DEPTH(3), .CLEAR_DATA(1'b0)) dut (
        .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(3), .CLEAR_DATA(1'b1)) dut_c (
        .Clk(Clk), .Reset(Reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_c),
        .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready),
        .count(count_c)
    );

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       st;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic       cd;     // compare out_data on this row
        logic [7:0] e_od;
        logic [1:0] e_cnt;
        logic       cz;     // CLEAR_DATA instance must show zero payload
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy,
                       input logic st, input logic fl, input logic e_ir,
                       input logic e_ov, input logic cd, input logic [7:0] e_od,
                       input logic [1:0] e_cnt, input logic cz);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.st = st; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.cd = cd; v.e_od = e_od;
        v.e_cnt = e_cnt; v.cz = cz;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [7:0] id, input logic ordy,
                         input logic st, input logic fl);
        in_valid = iv; in_data = id; out_ready = ordy; stall = st; flush = fl;
    endtask

    // Called just after a rising edge; leaves the bench just after the next one.
    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // ------------------------------------------------------------------
        // Stimulus table. Each row: inputs held for one cycle, outputs
        // expected mid-cycle (count reflects all previous edges).
        //   add(iv, id, ordy, st, fl, e_ir, e_ov, cd, e_od, e_cnt, cz)
        // ------------------------------------------------------------------
        // Streaming with out_ready=1: three edges of latency, then 1/cycle.
        add(1, 8'h11, 1, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 8'h22, 1, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        add(1, 8'h33, 1, 0, 0, 1, 0, 0, 8'h00, 2, 0);
        add(1, 8'h44, 1, 0, 0, 1, 1, 1, 8'h11, 3, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h22, 3, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h33, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h44, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        // Fill with out_ready=0, full chain refuses, then pass-through at full.
        add(1, 8'hA1, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 8'hA2, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        add(1, 8'hA3, 0, 0, 0, 1, 0, 0, 8'h00, 2, 0);
        add(1, 8'hA9, 0, 0, 0, 0, 1, 1, 8'hA1, 3, 0);
        add(1, 8'hA4, 1, 0, 0, 1, 1, 1, 8'hA1, 3, 0);
        add(0, 8'h00, 0, 0, 0, 0, 1, 1, 8'hA2, 3, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA2, 3, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA3, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'hA4, 1, 0);
        // Bubble collapse: 0x55 reaches stage 2, 0x66 slides into stage 1.
        add(1, 8'h55, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        add(1, 8'h66, 0, 0, 0, 1, 1, 1, 8'h55, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h55, 2, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h55, 2, 0);
        // Stall four cycles: handshakes masked, everything frozen.
        for (int k = 0; k < 4; k++) add(1, 8'h77, 1, 1, 0, 0, 0, 0, 8'h00, 2, 0);
        // Resume: 0x66 emerges right after 0x55, proving it sat in stage 1.
        add(1, 8'h77, 1, 0, 0, 1, 1, 1, 8'h55, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 1, 1, 8'h66, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 0, 8'h00, 1, 0);
        add(0, 8'h00, 0, 0, 0, 1, 1, 1, 8'h77, 1, 0);
        // Flush with count=2 and a beat offered.
        add(1, 8'h88, 0, 0, 0, 1, 1, 1, 8'h77, 1, 0);
        add(1, 8'h99, 1, 0, 1, 0, 0, 0, 8'h00, 2, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h77, 0, 1);
        // Flush together with stall: flush wins.
        add(1, 8'hBB, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        add(1, 8'hCC, 1, 1, 1, 0, 0, 0, 8'h00, 1, 0);
        add(0, 8'h00, 1, 0, 0, 1, 0, 1, 8'h77, 0, 0);

        // ------------------------------------------------------------------
        // Reset
        // ------------------------------------------------------------------
        drive(1, 8'hEE, 1, 0, 0);
        Reset = 1'b0;
        #13;
        chk("rst_out_valid", 0, out_valid, 0);
        chk("rst_in_ready",  0, in_ready,  0);
        chk("rst_count",     0, count,     0);
        chk("rst_clr_data",  0, out_data_c, 0);
        next_cycle();
        Reset = 1'b1;
        drive(0, 8'h00, 1, 0, 0);
        next_cycle();

        // ------------------------------------------------------------------
        // Table-driven section
        // ------------------------------------------------------------------
        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].st, vecs[i].fl);
            #4;
            chk("in_ready",  i, in_ready,  vecs[i].e_ir);
            chk("out_valid", i, out_valid, vecs[i].e_ov);
            chk("count",     i, count,     vecs[i].e_cnt);
            chk("c_in_ready",  i, in_ready_c,  vecs[i].e_ir);
            chk("c_out_valid", i, out_valid_c, vecs[i].e_ov);
            chk("c_count",     i, count_c,     vecs[i].e_cnt);
            if (vecs[i].cd) chk("out_data", i, out_data, vecs[i].e_od);
            if (vecs[i].cz) chk("c_out_data_zero", i, out_data_c, 0);
            next_cycle();
        end

        // ------------------------------------------------------------------
        // Asynchronous reset between edges with a full chain
        // ------------------------------------------------------------------
        drive(1, 8'hD1, 0, 0, 0); next_cycle();
        drive(1, 8'hD2, 0, 0, 0); next_cycle();
        drive(1, 8'hD3, 0, 0, 0); next_cycle();
        drive(0, 8'h00, 0, 0, 0);
        #2;
        chk("full_count", 0, count, 3);
        chk("full_out_valid", 0, out_valid, 1);
        chk("full_out_data", 0, out_data, 8'hD1);
        #1;
        Reset = 1'b0;
        #1;
        chk("async_out_valid", 0, out_valid, 0);
        chk("async_count",     0, count,     0);
        chk("async_in_ready",  0, in_ready,  0);
        next_cycle();
        #3;
        Reset = 1'b1;
        drive(0, 8'h00, 1, 0, 0);
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            #4;
            chk("post_rst_out_valid", k, out_valid, 0);
            chk("post_rst_count",     k, count,     0);
            next_cycle();
        end
        // A fresh beat after release still sees the full three-edge latency.
        drive(1, 8'hE1, 1, 0, 0);
        #4;
        chk("fresh_in_ready", 0, in_ready, 1);
        next_cycle();
        drive(0, 8'h00, 1, 0, 0);
        for (int k = 0; k < 2; k++) begin
            #4;
            chk("fresh_lat_out_valid", k, out_valid, 0);
            next_cycle();
        end
        #4;
        chk("fresh_out_valid", 0, out_valid, 1);
        chk("fresh_out_data",  0, out_data,  8'hE1);
        chk("fresh_count",     0, count,     1);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
`default_nettype wire
